// File: rtl/sw_event_device_pkg.sv
// Shared register map, CTRL bit positions and address decode helper
// for the switch event device.
package sw_event_device_pkg;

   localparam int DATA_OFF  = 0;
   localparam int CTRL_OFF  = 4;
   localparam int RISE_OFF  = 8;
   localparam int FALL_OFF  = 12;
   localparam int EVENT_OFF = 16;

   localparam int CTRL_READY = 0;
   localparam int CTRL_OVR   = 1;
   localparam int CTRL_FULL  = 2;
   localparam int CTRL_IE    = 4;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_DATA,
      REG_CTRL,
      REG_RISE,
      REG_FALL,
      REG_EVENT
   } reg_sel_e;

   // Only exact word offsets hit a register; anything else is not ours.
   function automatic reg_sel_e decode_offset(input logic [4:0] off);
      case (off)
         5'(DATA_OFF):  return REG_DATA;
         5'(CTRL_OFF):  return REG_CTRL;
         5'(RISE_OFF):  return REG_RISE;
         5'(FALL_OFF):  return REG_FALL;
         5'(EVENT_OFF): return REG_EVENT;
         default:       return REG_NONE;
      endcase
   endfunction

endpackage

// File: rtl/sw_event_device_if.sv
// I/O bus control signals shared between the processor and the switch device;
// the bidirectional data bus stays a plain inout port on the device.
interface sw_event_device_if #(
   parameter int WBITS = 32
);
   logic [WBITS-1:0] ABUS;
   logic             WE;
   logic             INTR;

   modport master (output ABUS, output WE, input INTR);
   modport slave  (input ABUS, input WE, output INTR);
endinterface

// File: rtl/sw_debounce_chan.sv
// One switch channel: two-flop synchroniser, candidate value and a saturating
// stability counter that strobes commit on the cycle it reaches DEBOUNCE_CYCLES.
module sw_debounce_chan #(
   parameter int DEBOUNCE_CYCLES = 900000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw,
   output logic commit,
   output logic cand
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1_reg, s2_reg, cand_reg;
   logic [CW-1:0] cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_reg   <= 1'b0;
         s2_reg   <= 1'b0;
         cand_reg <= 1'b0;
         cnt_reg  <= '0;
      end else begin
         s1_reg <= sw;
         s2_reg <= s1_reg;
         if (s2_reg != cand_reg) begin
            cand_reg <= s2_reg;
            cnt_reg  <= '0;
         end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   // High during the cycle whose closing edge moves cnt from LAST to MAX.
   assign commit = (s2_reg == cand_reg) && (cnt_reg == CNT_LAST);
   assign cand   = cand_reg;

endmodule

// File: rtl/sw_event_device.sv
// Memory-mapped debounced switch device with per-bit edge filtering and an
// event FIFO; raises INTR while events are queued and interrupts are enabled.
module sw_event_device
   import sw_event_device_pkg::*;
#(
   parameter int               WBITS           = 32,
   parameter int               DBITS           = 10,
   parameter int               CBITS           = 5,
   parameter logic [WBITS-1:0] BASE            = WBITS'(32'hF000_0014),
   parameter int               DEBOUNCE_CYCLES = 900000,
   parameter int               FIFO_DEPTH      = 4
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic [DBITS-1:0]    SW,
   sw_event_device_if.slave    bus,
   inout  wire  [WBITS-1:0]    DBUS
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = 2 * DBITS;

   logic [DBITS-1:0] data_reg, rise_en_reg, fall_en_reg;
   logic             ovr_reg, ie_reg;

   logic [DBITS-1:0] commit_vec, cand_vec;

   generate
      for (genvar gi = 0; gi < DBITS; gi++) begin : g_chan
         sw_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_chan (
            .clk    (CLK),
            .rst_n  (RESET_N),
            .sw     (SW[gi]),
            .commit (commit_vec[gi]),
            .cand   (cand_vec[gi])
         );
      end
   endgenerate

   logic [DBITS-1:0] data_next, rising, falling, ev_mask;

   always_comb begin
      data_next = (data_reg & ~commit_vec) | (cand_vec & commit_vec);
      rising    = commit_vec & cand_vec & ~data_reg;
      falling   = commit_vec & ~cand_vec & data_reg;
      ev_mask   = (rising & rise_en_reg) | (falling & fall_en_reg);
   end

   // Address decode
   logic [WBITS-1:0] offset;
   reg_sel_e         reg_sel;
   logic             rd_en, wr_en;

   always_comb begin
      offset  = bus.ABUS - BASE;
      reg_sel = REG_NONE;
      if (offset[WBITS-1:5] == '0)
         reg_sel = decode_offset(offset[4:0]);
   end

   assign rd_en = !bus.WE;
   assign wr_en = bus.WE;

   // Event FIFO
   logic [EW-1:0] fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] head_reg, tail_reg;
   logic [CW-1:0] count_reg;
   logic          fifo_empty, fifo_full, push_req, push, pop, ovr_set;

   assign fifo_empty = (count_reg == '0);
   assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
   assign push_req   = |ev_mask;
   assign pop        = rd_en && (reg_sel == REG_EVENT) && !fifo_empty;
   // A pop on the same edge frees the slot, so a full FIFO still accepts.
   assign push       = push_req && (!fifo_full || pop);
   assign ovr_set    = push_req && fifo_full && !pop;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (push)
            tail_reg <= tail_reg + 1'b1;
         if (pop)
            head_reg <= head_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (push)
         fifo_mem[tail_reg] <= {ev_mask, data_next};
   end

   // Registers
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         data_reg    <= '0;
         rise_en_reg <= '1;
         fall_en_reg <= '0;
         ovr_reg     <= 1'b0;
         ie_reg      <= 1'b0;
      end else begin
         data_reg <= data_next;
         if (wr_en && reg_sel == REG_RISE)
            rise_en_reg <= DBUS[DBITS-1:0];
         if (wr_en && reg_sel == REG_FALL)
            fall_en_reg <= DBUS[DBITS-1:0];
         if (wr_en && reg_sel == REG_CTRL) begin
            ie_reg <= DBUS[CTRL_IE];
            if (!DBUS[CTRL_OVR])
               ovr_reg <= 1'b0;
         end
         // A fresh overrun outranks a simultaneous clear.
         if (ovr_set)
            ovr_reg <= 1'b1;
      end
   end

   // Read path
   logic [CBITS-1:0] ctrl_val;
   logic [WBITS-1:0] rd_data;

   always_comb begin
      ctrl_val             = '0;
      ctrl_val[CTRL_READY] = !fifo_empty;
      ctrl_val[CTRL_OVR]   = ovr_reg;
      ctrl_val[CTRL_FULL]  = fifo_full;
      ctrl_val[CTRL_IE]    = ie_reg;
      rd_data              = '0;
      case (reg_sel)
         REG_DATA:  rd_data = WBITS'(data_reg);
         REG_CTRL:  rd_data = WBITS'(ctrl_val);
         REG_RISE:  rd_data = WBITS'(rise_en_reg);
         REG_FALL:  rd_data = WBITS'(fall_en_reg);
         REG_EVENT: if (!fifo_empty) rd_data = WBITS'(fifo_mem[head_reg]);
         default:   rd_data = '0;
      endcase
   end

   assign DBUS     = (rd_en && reg_sel != REG_NONE) ? rd_data : {WBITS{1'bz}};
   assign bus.INTR = !fifo_empty && ie_reg;

   wire unused_dbus = &{1'b0, DBUS};

endmodule

// File: tb/tb_sw_event_device.sv
// Randomised scoreboard bench for sw_event_device against a queue-based model
// of the debounced switch state, edge filters and event FIFO.
module tb_sw_event_device;
   import sw_event_device_pkg::*;

   localparam int WB = 32;
   localparam int DB = 10;
   localparam int DC = 4;
   localparam int FD = 4;
   localparam logic [31:0] BASE    = 32'hF000_0014;
   localparam logic [31:0] A_DATA  = BASE + 32'(DATA_OFF);
   localparam logic [31:0] A_CTRL  = BASE + 32'(CTRL_OFF);
   localparam logic [31:0] A_RISE  = BASE + 32'(RISE_OFF);
   localparam logic [31:0] A_FALL  = BASE + 32'(FALL_OFF);
   localparam logic [31:0] A_EVENT = BASE + 32'(EVENT_OFF);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DB-1:0] sw = '0;
   wire  [WB-1:0] dbus;
   logic          tb_drive = 1'b0;
   logic [WB-1:0] tb_wdata = '0;

   assign dbus = tb_drive ? tb_wdata : {WB{1'bz}};

   sw_event_device_if #(.WBITS(WB)) bus ();

   sw_event_device #(
      .WBITS           (WB),
      .DBITS           (DB),
      .CBITS           (5),
      .BASE            (BASE),
      .DEBOUNCE_CYCLES (DC),
      .FIFO_DEPTH      (FD)
   ) dut (
      .CLK     (clk),
      .RESET_N (rst_n),
      .SW      (sw),
      .bus     (bus),
      .DBUS    (dbus)
   );

   always #5 clk = ~clk;

   // Scoreboard
   typedef struct {
      string       name;
      logic [31:0] dbus;
      logic        intr;
   } exp_t;

   exp_t exp_q[$];
   logic rd_active = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   task automatic compare(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rd_active) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: read observed with no expectation queued");
         end else begin
            e = exp_q.pop_front();
            $display("rd %-16s dbus=%08h intr=%b", e.name, dbus, bus.INTR);
            compare({e.name, "_dbus"}, dbus, e.dbus);
            compare({e.name, "_intr"}, {31'b0, bus.INTR}, {31'b0, e.intr});
         end
      end
   end

   // Reference model
   logic [DB-1:0] m_data, m_rise, m_fall;
   logic          m_ovr, m_ie;
   logic [31:0]   m_q[$];

   function automatic void m_reset();
      m_data = '0;
      m_rise = '1;
      m_fall = '0;
      m_ovr  = 1'b0;
      m_ie   = 1'b0;
      m_q.delete();
   endfunction

   function automatic logic m_intr();
      return m_ie && (m_q.size() != 0);
   endfunction

   function automatic logic [31:0] m_ctrl();
      return {27'b0, m_ie, 1'b0, (m_q.size() == FD), m_ovr, (m_q.size() != 0)};
   endfunction

   // New debounced state becomes visible; emit an event if any enabled edge.
   function automatic void m_commit(logic [DB-1:0] nd);
      logic [DB-1:0] mask;
      mask = (nd & ~m_data & m_rise) | (~nd & m_data & m_fall);
      if (mask != 0) begin
         if (m_q.size() == FD)
            m_ovr = 1'b1;
         else
            m_q.push_back({12'b0, mask, nd});
      end
      m_data = nd;
   endfunction

   // Bus tasks: entered and left 1 ns after a rising edge.
   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd(string name, logic [31:0] addr, logic [31:0] exp_d, logic exp_i);
      exp_t e;
      e.name = name;
      e.dbus = exp_d;
      e.intr = exp_i;
      exp_q.push_back(e);
      bus.ABUS  = addr;
      bus.WE    = 1'b0;
      rd_active = 1'b1;
      @(posedge clk);
      #1;
      rd_active = 1'b0;
      bus.ABUS  = 32'h0;
   endtask

   task automatic wr(logic [31:0] addr, logic [31:0] val);
      bus.ABUS = addr;
      bus.WE   = 1'b1;
      tb_wdata = val;
      tb_drive = 1'b1;
      @(posedge clk);
      #1;
      bus.WE   = 1'b0;
      tb_drive = 1'b0;
      bus.ABUS = 32'h0;
      case (addr)
         A_CTRL: begin
            m_ie = val[4];
            if (!val[1]) m_ovr = 1'b0;
         end
         A_RISE:  m_rise = val[DB-1:0];
         A_FALL:  m_fall = val[DB-1:0];
         default: ;
      endcase
      $display("wr %08h <= %08h", addr, val);
   endtask

   task automatic rd_data();  rd("DATA", A_DATA, {22'b0, m_data}, m_intr()); endtask
   task automatic rd_ctrl();  rd("CTRL", A_CTRL, m_ctrl(), m_intr());       endtask
   task automatic rd_rise();  rd("RISE_EN", A_RISE, {22'b0, m_rise}, m_intr()); endtask
   task automatic rd_fall();  rd("FALL_EN", A_FALL, {22'b0, m_fall}, m_intr()); endtask

   task automatic rd_event();
      logic [31:0] e;
      logic        i;
      i = m_intr();
      e = 32'h0;
      if (m_q.size() != 0)
         e = m_q.pop_front();
      rd("EVENT", A_EVENT, e, i);
   endtask

   task automatic set_sw(logic [DB-1:0] v);
      sw = v;
      cyc(DC + 6);
      m_commit(v);
   endtask

   task automatic glitch(logic [DB-1:0] g, int len);
      logic [DB-1:0] base;
      base = sw;
      sw   = base ^ g;
      cyc(len);
      sw   = base;
      cyc(DC + 6);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0]   r, e0;
      logic [DB-1:0] g;
      logic [DB-1:0] burst [5];

      bus.ABUS = 32'h0;
      bus.WE   = 1'b0;
      m_reset();
      @(posedge clk);
      #1;

      // Reset state observed while reset is held
      rd_ctrl();
      rd_data();
      rd_rise();
      rd_fall();
      rst_n = 1'b1;
      cyc(DC + 6);

      // Single rising change: DATA flips exactly at P+2+DEBOUNCE_CYCLES
      sw = 10'h001;
      cyc(DC + 2);
      rd_data();
      m_commit(10'h001);
      rd_data();
      rd_ctrl();
      rd_event();
      rd_ctrl();

      // Falling edge with IE: INTR follows the commit, clears after the pop
      wr(A_CTRL, 32'h10);
      wr(A_FALL, 32'h001);
      sw = 10'h000;
      cyc(DC + 2);
      rd_ctrl();
      m_commit(10'h000);
      rd_ctrl();
      rd_event();
      rd_ctrl();

      // Short glitch: no commit, no event
      glitch(10'h004, 2);
      rd_data();
      rd_ctrl();

      // Five enabled changes with no reads: overrun
      wr(A_FALL, 32'h3FF);
      burst = '{10'h011, 10'h022, 10'h3FF, 10'h000, 10'h155};
      for (int k = 0; k < 5; k++)
         set_sw(burst[k]);
      rd_ctrl();
      wr(A_CTRL, 32'h10);
      rd_ctrl();

      // Full FIFO, pop on the same edge as a new event
      sw = 10'h0AA;
      cyc(DC + 2);
      e0 = m_q.pop_front();
      m_commit(10'h0AA);
      rd("EVENT_SAME_EDGE", A_EVENT, e0, 1'b1);
      rd_ctrl();
      for (int k = 0; k < 4; k++)
         rd_event();
      rd_ctrl();

      // Asynchronous reset mid-debounce with events pending
      set_sw(10'h300);
      sw = 10'h0F0;
      cyc(3);
      rst_n = 1'b0;
      m_reset();
      #1;
      compare("RST_INTR_IMMEDIATE", {31'b0, bus.INTR}, 32'h0);
      rd_data();
      rd_ctrl();
      rd_rise();
      rst_n = 1'b1;
      set_sw(sw);
      rd_data();
      rd_event();

      // Randomised traffic
      for (int n = 0; n < 200; n++) begin
         r = $urandom();
         case ($urandom_range(0, 8))
            0, 1: set_sw(r[DB-1:0]);
            2: begin
               g = r[DB-1:0];
               if (g == '0) g = 10'h200;
               glitch(g, int'($urandom_range(1, DC - 1)));
            end
            3: wr(A_RISE, r);
            4: wr(A_FALL, r);
            5: begin
               case ($urandom_range(0, 3))
                  0:       wr(A_DATA, r);
                  1:       wr(A_EVENT, r);
                  default: wr(A_CTRL, r);
               endcase
            end
            6, 7: rd_event();
            default: begin
               case ($urandom_range(0, 3))
                  0:       rd_data();
                  1:       rd_ctrl();
                  2:       rd_rise();
                  default: rd_fall();
               endcase
            end
         endcase
      end

      while (m_q.size() != 0)
         rd_event();
      rd_ctrl();

      cyc(2);
      compare("SCOREBOARD_DRAINED", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sw_event_device.md
# sw_event_device

Memory-mapped switch input device for the processor's I/O bus: a parametrised successor to the single-register switch device. Each of DBITS switch inputs has its own synchroniser and debounce counter. A per-bit rising/falling edge filter selects which committed changes count as events, and events are queued in a small FIFO so bursts are not lost. It sits on the shared ABUS/DBUS next to the other I/O devices and drives one interrupt line to the interrupt controller.

## Interface
- WBITS, 32: bus address/data width.
- DBITS, 10: number of switch channels; 2*DBITS <= WBITS is required.
- CBITS, 5: CTRL register width.
- BASE, 32'hF0000014: byte address of register 0.
- DEBOUNCE_CYCLES, 900000: consecutive stable cycles required to commit a change; must be >= 1.
- FIFO_DEPTH, 4: event queue depth; must be a power of two and >= 2.
- CLK  in  1  system clock; all state updates on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset; clears all state immediately.
- SW  in  DBITS  raw, asynchronous switch pins.
- ABUS  in  WBITS  bus address.
- DBUS  inout  WBITS  bus data; driven only during a read of a selected register, high-Z otherwise.
- WE  in  1  bus write enable; the bus reads when WE=0.
- INTR  out  1  interrupt request; reset value 0.

## Operation
- Register map (zero-extended on read; writes to read-only registers are ignored):
  - BASE+0 DATA: RO, current debounced state.
  - BASE+4 CTRL: see CTRL bit layout below.
  - BASE+8 RISE_EN: RW, DBITS wide, reset all-ones.
  - BASE+12 FALL_EN: RW, DBITS wide, reset 0.
  - BASE+16 EVENT: RO, reading it pops the FIFO.
- CTRL bit layout:
  - [0] READY: RO, equals FIFO not empty.
  - [1] OVR: sticky. Writing 0 clears it; writing 1 has no effect.
  - [2] FULL: RO.
  - [3]: reads 0.
  - [4] IE: RW.
- INTR = READY & IE, driven combinationally from registers.
- Per-channel processing:
  - Two-flop synchroniser s1→s2.
  - If s2 != cand: cand <= s2 and cnt <= 0.
  - Otherwise cnt increments, saturating at DEBOUNCE_CYCLES.
  - On the edge where cnt goes from DEBOUNCE_CYCLES-1 to DEBOUNCE_CYCLES: DATA[i] <= cand. This is a commit; it is a change only if cand != DATA[i].
- Event detection: ev_mask = (rising & RISE_EN) | (falling & FALL_EN), evaluated over all channels committing on the same edge.
  - If ev_mask != 0, push the entry {ev_mask, new DATA} into the FIFO.
  - Bits [2*DBITS-1:DBITS] hold ev_mask, bits [DBITS-1:0] hold new DATA, and the remaining upper bits are 0.
  - Simultaneous commits on several channels produce one entry.
  - Changes with ev_mask = 0 update DATA silently.
- EVENT read (!WE, ABUS = BASE+16):
  - DBUS shows the FIFO head combinationally.
  - The FIFO pops on each rising edge while the read is asserted.
  - A read while empty returns 0 and does not pop.
- FIFO boundary cases:
  - Push and pop on the same edge: both happen, count unchanged. This includes the full case, where it is not an overrun.
  - Push while full without a pop: the new entry is dropped and OVR is set.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset behaviour:
  - After reset: DATA=0 and RISE_EN=all-ones, so switches held high produce a rising event after debounce.
  - RESET_N low at any time clears the synchronisers, cnt, cand, DATA, FIFO, OVR, IE and FALL_EN, and sets RISE_EN to all-ones.
- A CTRL/RISE_EN/FALL_EN write takes effect at the same edge as a concurrent commit; the commit uses the pre-write enables.

## Timing
- Pin latency: SW[i] changes before edge P and stays stable.
  - s2 updates at P+1, cand at P+2.
  - DATA and the FIFO push happen at P+2+DEBOUNCE_CYCLES.
  - INTR rises directly after that edge if IE=1.
- A glitch that returns to the old value before the commit restarts cnt; there is no event and no DATA change.
- Pop effect: after the popping edge, READY/INTR reflect the new count; INTR falls after popping the last entry.
- Register writes take effect on the edge where WE=1 and the address matches.

## Structure
- Shared package holds:
  - Register offsets (DATA_OFF=0, CTRL_OFF=4, RISE_OFF=8, FALL_OFF=12, EVENT_OFF=16).
  - CTRL bit indices (READY=0, OVR=1, FULL=2, IE=4).
- Sub-module sw_debounce_chan: one instance per channel.
  - Contains s1/s2, cand, cnt and the commit strobe.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - Outputs are the commit strobe and cand.
- The FIFO (register array, head/tail pointers, count with FIFO_DEPTH+1 states) is written inline in the top module.

## Test plan
All tests use DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, DBITS=10.
- Reset then SW=0x001 stable → DATA=0x001 at P+6; EVENT reads 0x00401; READY goes 1→0 after the read.
- IE=1, FALL_EN=0x001, SW 0x001→0x000 → INTR=1; EVENT = {0x001, 0x000}; INTR=0 after the pop.
- SW bit toggles for 2 cycles and back → no DATA change, READY stays 0.
- Five enabled changes without reads → 4 entries, FULL=1, OVR=1, oldest entry read first. Writing CTRL=0x10 clears OVR and keeps IE.
- FIFO full, a read asserted on the same edge as a new event → no OVR; count stays 4; the tail holds the new entry.
- RESET_N pulsed low mid-debounce with the FIFO non-empty → INTR=0, DATA=0, READY=0 immediately; DBUS is high-Z when no read is addressed.
